lu_sweep: RTL

LU_SWEEP -- requirements
Module: lu_sweep

---
 rtl/lu_pkg.sv | 19 +
 rtl/lu_ref_model.sv | 23 ++
 rtl/lu_sweep.sv | 116 +++++++++++
 3 files changed

// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit sweep: FSM states, select codes and
// the truth-table word a correct logic unit should reproduce.
package lu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StDone = 2'd2
  } lu_state_e;

  localparam logic [1:0] SEL_NOR  = 2'b00;
  localparam logic [1:0] SEL_OR   = 2'b01;
  localparam logic [1:0] SEL_XNOR = 2'b10;
  localparam logic [1:0] SEL_XOR  = 2'b11;

  // Bit i is the correct result for vector index i = {select, a, b}.
  localparam logic [15:0] EXPECTED_WORD = 16'h69E1;

endpackage

// File: rtl/lu_ref_model.sv
// Golden combinational model of the logic unit under test.
module lu_ref_model
  import lu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] select,
  output logic       expected
);

  // Decode the operation code into the reference result bit.
  always_comb begin
    expected = 1'b0;
    unique case (select)
      SEL_NOR:  expected = ~(a | b);
      SEL_OR:   expected = a | b;
      SEL_XNOR: expected = ~(a ^ b);
      SEL_XOR:  expected = a ^ b;
      default:  expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/lu_sweep.sv
// Exhaustive tester for a 2-input, 4-operation logic unit: drives all 16
// {select, a, b} vectors, holds each for SETTLE cycles, captures the result
// and counts mismatches against the reference model.
module lu_sweep
  import lu_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        lu_out,
  output logic        a,
  output logic        b,
  output logic [1:0]  select,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_word,
  output logic [4:0]  error_count,
  output logic        pass
);

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  lu_state_e   r_state;
  logic [3:0]  r_idx;
  logic [3:0]  r_cnt;
  logic        r_a;
  logic        r_b;
  logic [1:0]  r_select;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_table;
  logic [4:0]  r_err;
  logic        r_pass;
  logic        w_expected;

  // Reference bit for the vector currently on the operand outputs.
  lu_ref_model u_ref (
    .a        (r_a),
    .b        (r_b),
    .select   (r_select),
    .expected (w_expected)
  );

  // Sweep FSM; all outputs are registered so the logic unit sees clean operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_idx    <= 4'd0;
      r_cnt    <= 4'd0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_select <= 2'b00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_table  <= 16'h0000;
      r_err    <= 5'd0;
      r_pass   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_table  <= 16'h0000;
            r_err    <= 5'd0;
            r_pass   <= 1'b0;
            r_idx    <= 4'd0;
            r_cnt    <= 4'd0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_select <= 2'b00;
            r_busy   <= 1'b1;
            r_state  <= StHold;
          end
        end
        StHold: begin
          if (r_cnt == SettleLast) begin
            // Last edge of the settle window: capture and score this vector.
            r_table[r_idx] <= lu_out;
            if (lu_out != w_expected) begin
              r_err <= r_err + 5'd1;
            end
            r_cnt <= 4'd0;
            if (r_idx != 4'd15) begin
              r_idx                   <= r_idx + 4'd1;
              {r_select, r_a, r_b}    <= r_idx + 4'd1;
            end else begin
              {r_select, r_a, r_b}    <= 4'd0;
              r_busy                  <= 1'b0;
              r_done                  <= 1'b1;
              r_state                 <= StDone;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_pass  <= (r_err == 5'd0);
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign a           = r_a;
  assign b           = r_b;
  assign select      = r_select;
  assign busy        = r_busy;
  assign done        = r_done;
  assign table_word  = r_table;
  assign error_count = r_err;
  assign pass        = r_pass;

endmodule
